// File: rtl/ctr_pr5_dec_pkg.sv
// Purpose: shared constants, FSM encoding and replica feedback for the 5-bit pseudo-random count decoder.
// Latency: n/a (package only).
// Backpressure: n/a.
package ctr_pr5_dec_pkg;

   // Feedback LUT of the pseudo-random counter, indexed by {h[1], r[4], r[1], r[0]}.
   localparam logic [15:0] PR5_LUT = 16'hC34B;
   localparam int          CW      = 5;   // count word width
   localparam int          HW      = 2;   // history width

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SEARCH = 2'd1,
      ST_REPORT = 2'd2
   } state_t;

   // Next shift-in bit of the counter for the given state and history.
   function automatic logic pr5_fb(input logic [CW-1:0] r, input logic [HW-1:0] h);
      return PR5_LUT[{h[1], r[4], r[1], r[0]}];
   endfunction

endpackage

// File: rtl/ctr_pr5_dec_if.sv
// Purpose: request/result bundle of the decoder (start/code in, busy/done/found/value out).
// Latency: n/a (wires only).
// Backpressure: none; start is only accepted while the decoder is idle (busy=0).
interface ctr_pr5_dec_if
   import ctr_pr5_dec_pkg::*;
#(
   parameter int VW = 6
) ();

   logic          start;
   logic [CW-1:0] code;
   logic          busy;
   logic          done;
   logic          found;
   logic [VW-1:0] value;

   modport master (output start, code, input busy, done, found, value);
   modport slave  (input start, code, output busy, done, found, value);

endinterface

// File: rtl/ctr_pr5_ref.sv
// Purpose: replica of the 5-bit pseudo-random counter (state r, history h).
// Latency: r updates one clk after clr/step.  Ports: clk, rst_n, clr, step in; r out.
// Backpressure: none; clr has priority over step.
module ctr_pr5_ref
   import ctr_pr5_dec_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          step,
   output logic [CW-1:0] r
);

   logic [HW-1:0] h;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r <= '0;
         h <= '0;
      end else if (clr) begin
         r <= '0;
         h <= '0;
      end else if (step) begin
         r <= {r[CW-2:0], pr5_fb(r, h)};
         h <= {h[0], r[CW-1]};
      end
   end

endmodule

// File: rtl/ctr_pr5_dec.sv
// Purpose: decode a pseudo-random count word back to its step index by replaying the counter.
// Latency: start sampled at edge T, match at step k -> done in the cycle after edge T+k+2.
// Backpressure: start/code ignored while busy; ports clk, rst_n and bus (start, code, busy, done, found, value).
module ctr_pr5_dec
   import ctr_pr5_dec_pkg::*;
#(
   parameter int MAX_STEPS = 32,
   parameter int VW        = 6     // must satisfy 2**VW > MAX_STEPS
) (
   input  logic            clk,
   input  logic            rst_n,
   ctr_pr5_dec_if.slave    bus
);

   // Assert asynchronously, release synchronously to clk.
   logic [1:0] rst_pipe;
   logic       rst_i_n;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rst_pipe <= '0;
      else        rst_pipe <= {rst_pipe[0], 1'b1};
   end
   assign rst_i_n = rst_pipe[1];

   state_t        state_q, state_d;
   logic [CW-1:0] code_q;
   logic [VW-1:0] k_q;
   logic [CW-1:0] r;
   logic          ref_clr, ref_step, load, hit, miss;
   logic          res_found_q;
   logic [VW-1:0] res_value_q;
   logic          done_q, found_q;
   logic [VW-1:0] value_q;

   ctr_pr5_ref u_ref (
      .clk   (clk),
      .rst_n (rst_i_n),
      .clr   (ref_clr),
      .step  (ref_step),
      .r     (r)
   );

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // Match is tested before the step limit so a hit on the last position still counts.
   always_comb begin
      state_d  = state_q;
      ref_clr  = 1'b0;
      ref_step = 1'b0;
      load     = 1'b0;
      hit      = 1'b0;
      miss     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (bus.start) begin
               load    = 1'b1;
               ref_clr = 1'b1;
               state_d = ST_SEARCH;
            end
         end
         ST_SEARCH: begin
            if (r == code_q) begin
               hit     = 1'b1;
               state_d = ST_REPORT;
            end else if (k_q == VW'(MAX_STEPS - 1)) begin
               miss    = 1'b1;
               state_d = ST_REPORT;
            end else begin
               ref_step = 1'b1;
            end
         end
         ST_REPORT: state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_i_n) begin
      if (!rst_i_n) begin
         code_q      <= '0;
         k_q         <= '0;
         res_found_q <= 1'b0;
         res_value_q <= '0;
         done_q      <= 1'b0;
         found_q     <= 1'b0;
         value_q     <= '0;
      end else begin
         if (load)          code_q <= bus.code;
         if (load)          k_q    <= '0;
         else if (ref_step) k_q    <= k_q + 1'b1;

         if (hit) begin
            res_found_q <= 1'b1;
            res_value_q <= k_q;
         end else if (miss) begin
            res_found_q <= 1'b0;
            res_value_q <= '1;
         end

         // Result is published on the way out of REPORT and held until the next one.
         done_q <= (state_q == ST_REPORT);
         if (state_q == ST_REPORT) begin
            found_q <= res_found_q;
            value_q <= res_value_q;
         end
      end
   end

   assign bus.busy  = (state_q != ST_IDLE);
   assign bus.done  = done_q;
   assign bus.found = found_q;
   assign bus.value = value_q;

endmodule
